// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Register-file index as carried in the instruction rs/rt fields
    typedef logic [4:0] reg_idx_t;

    // $zero never carries a real dependency
    localparam reg_idx_t REG_ZERO = 5'd0;

    // Default number of MEM_WAIT busy cycles tolerated before flagging a timeout
    localparam int MEM_TIMEOUT_DEF = 15;

    // Default width of the stall counter
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the pipeline datapath (supplies hazard inputs, consumes controls).
// slave:  the hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    reg_idx_t id_rs;
    reg_idx_t id_rt;
    logic     ex_memread;
    reg_idx_t ex_rt;
    logic     mem_branch_taken;
    logic     mem_busy;

    logic     pc_write;
    logic     ifid_write;
    logic     idex_bubble;
    logic     flush;
    logic     pipe_hold;

    modport master (
        output id_rs, id_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
        input  pc_write, ifid_write, idex_bubble, flush, pipe_hold
    );

    modport slave (
        input  id_rs, id_rt, ex_memread, ex_rt, mem_branch_taken, mem_busy,
        output pc_write, ifid_write, idex_bubble, flush, pipe_hold
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register the
// instruction in ID reads, and that register is not $zero.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic     ex_memread,
    input  reg_idx_t ex_rt,
    input  reg_idx_t id_rs,
    input  reg_idx_t id_rt,
    output logic     load_use
);

    assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// data-memory wait handling, plus stall statistics and a sticky timeout flag.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    pipe_hazard_ctrl_if.slave     pif,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  timeout_err
);

    // Wait counter is at least 4 bits and always wide enough to hold MEM_TIMEOUT
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_inc;
    logic              load_use;
    logic              wait_busy;
    logic              pc_write_d;
    logic              ifid_write_d;
    logic              idex_bubble_d;
    logic              flush_d;
    logic              pipe_hold_d;

    // Saturating increment: the statistic sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    hazard_detect u_hazard_detect (
        .ex_memread (pif.ex_memread),
        .ex_rt      (pif.ex_rt),
        .id_rs      (pif.id_rs),
        .id_rt      (pif.id_rt),
        .load_use   (load_use)
    );

    assign wait_busy = (state_q == MEM_WAIT) && pif.mem_busy;
    assign wait_inc  = wait_cnt_q + WAIT_W'(1);

    // Next-state and control decode; reset forces a full pipeline freeze
    always_comb begin
        state_d       = state_q;
        pc_write_d    = 1'b1;
        ifid_write_d  = 1'b1;
        idex_bubble_d = 1'b0;
        flush_d       = 1'b0;
        pipe_hold_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (pif.mem_busy) begin
                    pipe_hold_d  = 1'b1;
                    pc_write_d   = 1'b0;
                    ifid_write_d = 1'b0;
                    state_d      = MEM_WAIT;
                end else if (pif.mem_branch_taken) begin
                    flush_d = 1'b1;
                    state_d = FLUSH;
                end else if (load_use) begin
                    // One stall: the bubble inserted now removes the match next cycle
                    pc_write_d    = 1'b0;
                    ifid_write_d  = 1'b0;
                    idex_bubble_d = 1'b1;
                end
            end
            FLUSH: begin
                // Squashed slot: load-use is meaningless here, only memory can stall
                if (pif.mem_busy) begin
                    pipe_hold_d  = 1'b1;
                    pc_write_d   = 1'b0;
                    ifid_write_d = 1'b0;
                    state_d      = MEM_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (pif.mem_busy) begin
                    pipe_hold_d  = 1'b1;
                    pc_write_d   = 1'b0;
                    ifid_write_d = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (!reset) begin
            pc_write_d    = 1'b0;
            ifid_write_d  = 1'b0;
            idex_bubble_d = 1'b0;
            flush_d       = 1'b0;
            pipe_hold_d   = 1'b1;
        end
    end

    assign pif.pc_write    = pc_write_d;
    assign pif.ifid_write  = ifid_write_d;
    assign pif.idex_bubble = idex_bubble_d;
    assign pif.flush       = flush_d;
    assign pif.pipe_hold   = pipe_hold_d;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Memory wait counter and sticky timeout flag; FSM keeps waiting after a timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state_q != MEM_WAIT) && (state_d == MEM_WAIT)) begin
                wait_cnt_q <= '0;
            end else if (wait_busy && (wait_cnt_q != WAIT_LIMIT)) begin
                wait_cnt_q <= wait_inc;
                if (wait_inc == WAIT_LIMIT) timeout_err <= 1'b1;
            end
        end
    end

    // Total stall cycles: every cycle the PC is not allowed to advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           stall_cnt <= '0;
        else if (!pc_write_d) stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    // Control vector order: {pc_write, ifid_write, idex_bubble, flush, pipe_hold}
    localparam logic [4:0] C_DEF  = 5'b11000;
    localparam logic [4:0] C_HOLD = 5'b00001;
    localparam logic [4:0] C_LU   = 5'b00100;
    localparam logic [4:0] C_FL   = 5'b11010;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] stall_cnt;
    logic          timeout_err;
    logic [4:0]    ctl;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic m_prev_busy;
    logic m_prev_flush;
    logic m_err;
    int   m_stall;
    int   m_run;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if pif ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pif         (pif),
        .stall_cnt   (stall_cnt),
        .timeout_err (timeout_err)
    );

    assign ctl = {pif.pc_write, pif.ifid_write, pif.idex_bubble, pif.flush, pif.pipe_hold};

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] ert, input logic br, input logic bz);
        pif.id_rs            = rs;
        pif.id_rt            = rt;
        pif.ex_memread       = mr;
        pif.ex_rt            = ert;
        pif.mem_branch_taken = br;
        pif.mem_busy         = bz;
    endtask

    // Apply inputs for the current cycle and move to the sampling point
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] ert, input logic br, input logic bz);
        drive(rs, rt, mr, ert, br, bz);
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Expected controls from the hazard rules, given the previous cycle's events
    function automatic logic [4:0] ref_ctl(input logic bz, input logic br, input logic lu);
        if (bz) return C_HOLD;
        if (m_prev_busy || m_prev_flush) return C_DEF;
        if (br) return C_FL;
        if (lu) return C_LU;
        return C_DEF;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 1'b0, 0, 1'b0, 1'b0);
        #3;
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_HOLD);
        end
        checks++;
        if ({stall_cnt, timeout_err} !== {CW'(0), 1'b0}) begin
            errors++; $display("FAIL reset_regs got=%0d/%b exp=0/0", stall_cnt, timeout_err);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL reset_release got=%b exp=%b", ctl, C_DEF);
        end
        nxt();
    endtask

    task automatic test_load_use();
        do_reset();
        step(8, 3, 1'b1, 8, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL lu_rs_stall got=%b exp=%b", ctl, C_LU);
        end
        nxt();
        step(8, 3, 1'b0, 4, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL lu_release got=%b exp=%b", ctl, C_DEF);
        end
        checks++;
        if (stall_cnt !== CW'(1)) begin
            errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt);
        end
        nxt();
        step(1, 9, 1'b1, 9, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL lu_rt_stall got=%b exp=%b", ctl, C_LU);
        end
        nxt();
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== CW'(2)) begin
            errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt);
        end
        nxt();
    endtask

    task automatic test_zero_reg();
        do_reset();
        step(0, 5, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL zero_reg got=%b exp=%b", ctl, C_DEF);
        end
        nxt();
        step(6, 7, 1'b1, 5, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL no_match got=%b exp=%b", ctl, C_DEF);
        end
        nxt();
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== CW'(0)) begin
            errors++; $display("FAIL zero_stall_cnt got=%0d exp=0", stall_cnt);
        end
        nxt();
    endtask

    task automatic test_branch_priority();
        do_reset();
        step(8, 0, 1'b1, 8, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_FL) begin
            errors++; $display("FAIL br_over_lu got=%b exp=%b", ctl, C_FL);
        end
        nxt();
        step(8, 0, 1'b1, 8, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL flush_ignores_lu got=%b exp=%b", ctl, C_DEF);
        end
        nxt();
        step(8, 0, 1'b1, 8, 1'b0, 1'b0);
        checks++;
        if (ctl !== C_LU) begin
            errors++; $display("FAIL run_after_flush got=%b exp=%b", ctl, C_LU);
        end
        nxt();
        step(0, 0, 1'b0, 0, 1'b1, 1'b1);
        checks++;
        if (ctl !== C_HOLD) begin
            errors++; $display("FAIL busy_over_br got=%b exp=%b", ctl, C_HOLD);
        end
        nxt();
        step(0, 0, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_DEF) begin
            errors++; $display("FAIL wait_exit got=%b exp=%b", ctl, C_DEF);
        end
        nxt();
        step(0, 0, 1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_FL) begin
            errors++; $display("FAIL held_branch got=%b exp=%b", ctl, C_FL);
        end
        nxt();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1'b0, 0, 1'b0, 1'b1);
            checks++;
            if (ctl !== C_HOLD) begin
                errors++; $display("FAIL mem_hold[%0d] got=%b exp=%b", i, ctl, C_HOLD);
            end
            nxt();
        end
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({ctl, stall_cnt, timeout_err} !== {C_DEF, CW'(3), 1'b0}) begin
            errors++;
            $display("FAIL mem_release got=%b/%0d/%b exp=%b/3/0", ctl, stall_cnt, timeout_err, C_DEF);
        end
        nxt();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1'b0, 0, 1'b0, 1'b1);
            if (i == 3) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    errors++; $display("FAIL timeout_early got=%b exp=0", timeout_err);
                end
            end
            nxt();
        end
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_set got=%b exp=1", timeout_err);
        end
        nxt();
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
        end
        nxt();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1'b0, 0, 1'b0, 1'b1);
            nxt();
        end
        drive(0, 0, 1'b0, 0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ctl, stall_cnt, timeout_err} !== {C_HOLD, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL async_reset got=%b/%0d/%b exp=%b/0/0", ctl, stall_cnt, timeout_err, C_HOLD);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if ({ctl, stall_cnt, timeout_err} !== {C_DEF, CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL after_async got=%b/%0d/%b exp=%b/0/0", ctl, stall_cnt, timeout_err, C_DEF);
        end
        nxt();
    endtask

    task automatic test_stall_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(3, 0, 1'b1, 3, 1'b0, 1'b0);
            if (i == 15) begin
                checks++;
                if (stall_cnt !== CW'(15)) begin
                    errors++; $display("FAIL stall_at_max got=%0d exp=15", stall_cnt);
                end
            end
            nxt();
        end
        step(0, 0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== CW'(15)) begin
            errors++; $display("FAIL stall_saturate got=%0d exp=15", stall_cnt);
        end
        nxt();
    endtask

    task automatic test_random();
        logic [4:0] rs, rt, ert, exp_ctl;
        logic       mr, br, bz, lu;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                do_reset();
                m_prev_busy  = 1'b0;
                m_prev_flush = 1'b0;
                m_err        = 1'b0;
                m_stall      = 0;
                m_run        = 0;
            end
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            ert = 5'($urandom_range(0, 3));
            mr  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 5) == 0);
            bz  = ($urandom_range(0, 3) == 0);
            lu  = mr && (ert != 0) && ((ert == rs) || (ert == rt));
            step(rs, rt, mr, ert, br, bz);
            exp_ctl = ref_ctl(bz, br, lu);
            checks++;
            if ({ctl, stall_cnt, timeout_err} !== {exp_ctl, CW'(m_stall), m_err}) begin
                errors++;
                $display("FAIL random[%0d] got=%b/%0d/%b exp=%b/%0d/%b", i, ctl, stall_cnt,
                         timeout_err, exp_ctl, m_stall, m_err);
            end
            if (!exp_ctl[4] && (m_stall < (1 << CW) - 1)) m_stall++;
            if (bz) begin
                m_run++;
                if (m_run > TO) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
            m_prev_busy  = bz;
            m_prev_flush = exp_ctl[1];
            nxt();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_stall_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
